// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states
// and the alignment rule used to flag faults at request acceptance.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READ,
    WRITE,
    RESP
  } lsu_state_e;

  // Alignment only; the illegal size encoding is rejected separately.
  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] offset);
    case (size)
      SZ_HALF: return offset[0];
      SZ_WORD: return |offset;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response channel of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extract/extend load data from a memory word and
// merge sub-word store data into the previously read word.
import lsu_pkg::*;

module lsu_lane_align (
  input  logic [31:0] load_word,
  input  lsu_size_e   size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = '0;
    lane_h    = '0;
    load_data = load_word;
    case (offset)
      2'd0: lane_b = load_word[7:0];
      2'd1: lane_b = load_word[15:8];
      2'd2: lane_b = load_word[23:16];
      2'd3: lane_b = load_word[31:24];
      default: lane_b = '0;
    endcase
    lane_h = offset[1] ? load_word[31:16] : load_word[15:0];
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: load_data = is_unsigned ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_data = load_word;
    endcase
  end

  always_comb begin
    store_word = old_word;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0: store_word[7:0]   = wdata[7:0];
          2'd1: store_word[15:8]  = wdata[7:0];
          2'd2: store_word[23:16] = wdata[7:0];
          2'd3: store_word[31:24] = wdata[7:0];
          default: store_word = old_word;
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) store_word[31:16] = wdata[15:0];
        else           store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute stage and data memory: one transaction at a
// time, byte->word addressing, load extension and read-modify-write sub-word stores.
import lsu_pkg::*;

module load_store_unit #(
  parameter int unsigned ADDR_BITS = 22
) (
  input  logic                 clk,
  input  logic                 reset,
  load_store_unit_if.slave     bus,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic [31:0]          mem_dataIn,
  output logic                 mem_writeEnable,
  input  logic [31:0]          mem_dataOut
);

  lsu_state_e  state, state_next;
  lsu_size_e   req_size_in;
  lsu_size_e   size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        fault_q;
  logic [31:0] rdata_q;
  logic [31:0] addr_hi;
  logic        req_fault;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_size_in = lsu_size_e'(bus.req_size);
  assign addr_hi     = bus.req_addr >> (ADDR_BITS + 2);
  assign req_fault   = (req_size_in == SZ_ILLEGAL)
                     | is_misaligned(req_size_in, bus.req_addr[1:0])
                     | (|addr_hi);

  lsu_lane_align u_align (
    .load_word  (mem_dataOut),
    .size       (size_q),
    .offset     (off_q),
    .is_unsigned(uns_q),
    .load_data  (load_data),
    .old_word   (mem_dataOut),
    .wdata      (wdata_q),
    .store_word (store_word)
  );

  // rdata_q is cleared on every accept so stores and faults respond with 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      off_q       <= '0;
      wdata_q     <= '0;
      fault_q     <= 1'b0;
      rdata_q     <= '0;
      mem_address <= '0;
      mem_dataIn  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            size_q      <= req_size_in;
            uns_q       <= bus.req_unsigned;
            off_q       <= bus.req_addr[1:0];
            wdata_q     <= bus.req_wdata;
            fault_q     <= req_fault;
            rdata_q     <= '0;
            mem_address <= bus.req_addr[ADDR_BITS+1:2];
            if (bus.req_write) mem_dataIn <= bus.req_wdata;
          end
        end
        LOAD:    rdata_q    <= load_data;
        READ:    mem_dataIn <= store_word;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next          = state;
    bus.req_ready       = 1'b0;
    bus.resp_valid      = 1'b0;
    bus.resp_fault      = 1'b0;
    bus.resp_rdata      = '0;
    mem_writeEnable     = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_fault)                      state_next = RESP;
          else if (!bus.req_write)            state_next = LOAD;
          else if (req_size_in == SZ_WORD)    state_next = WRITE;
          else                                state_next = READ;
        end
      end
      LOAD:  state_next = RESP;
      READ:  state_next = WRITE;
      WRITE: begin
        mem_writeEnable = 1'b1;
        state_next      = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_fault = fault_q;
        bus.resp_rdata = rdata_q;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the CPU execute stage and the data memory. Accepts one byte/half/word load or store per transaction over a valid/ready handshake. Converts byte addresses to word addresses, sign/zero-extends loads, and performs read-modify-write for sub-word stores. Reports misaligned or out-of-range accesses as faults without touching memory.

## Interface
Parameters:
- ADDR_BITS, 22, word-address width of the data memory port.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  qualifies resp_valid
- mem_address  out  ADDR_BITS  word address = latched req_addr[ADDR_BITS+1:2]
- mem_dataIn  out  32  write word
- mem_writeEnable  out  1  memory write strobe
- mem_dataOut  in  32  memory read word, combinational from mem_address

## Operation
- States: IDLE, LOAD, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch all req_* fields and evaluate fault.
- Fault: size==3; half with addr[0]=1; word with addr[1:0]!=0; any bit of addr[31:ADDR_BITS+2] set. Next state RESP with fault=1. No memory cycle.
- Load: IDLE -> LOAD -> RESP. In LOAD, capture mem_dataOut and extract lane addr[1:0] (byte) or addr[1] (half), little-endian. Extend per req_unsigned.
- Word store: IDLE -> WRITE -> RESP. mem_dataIn = req_wdata.
- Sub-word store: IDLE -> READ -> WRITE -> RESP. READ captures the old word. WRITE drives the old word with only the addressed byte/half replaced by req_wdata[7:0]/[15:0].
- mem_writeEnable=1 only in WRITE, exactly one cycle per store.
- RESP: resp_valid=1, then back to IDLE.
- No overlap: a new request is accepted only after RESP completes.
- Synchronous reset (any state) -> IDLE. The pending operation is discarded with no response. A WRITE state coinciding with reset still drives the strobe that cycle, because the strobe is decoded from the current state.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_fault 0, mem_address 0, mem_dataIn 0, mem_writeEnable 0.

## Timing
- Acceptance edge = E0 (req_valid & req_ready).
- Fault: resp_valid high in the cycle after E0.
- Load and word store: resp_valid high in the 2nd cycle after E0.
- Sub-word store: resp_valid high in the 3rd cycle after E0.
- Throughput: one op per 2/3/4 cycles (fault/load-or-word-store/sub-word store), counting the IDLE accept cycle.
- Memory port:
  - mem_address is registered and stable from the cycle after E0 through RESP.
  - mem_dataOut is sampled at the end of LOAD/READ.
  - The write commits at the end of WRITE.
- resp_rdata and resp_fault are valid only while resp_valid=1. Otherwise they are held at 0.

## Structure
- Package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum
  - function is_misaligned(size, addr[1:0])
- Sub-module lsu_lane_align (combinational) holds:
  - load extract/extend: word, size, offset, unsigned -> 32b
  - store merge: old word, wdata, size, offset -> 32b
- FSM, request latches and handshake live in load_store_unit.

## Test plan
- Word store then load:
  - store addr 0x10, data 0xDEADBEEF -> one strobe with mem_address=4, mem_dataIn=0xDEADBEEF.
  - load word 0x10 -> resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept.
- Signed vs unsigned byte load, memory word 0x0000_8000 at addr 0x20:
  - lb addr 0x21 -> 0xFFFFFF80.
  - lbu addr 0x21 -> 0x00000080.
- Sub-word store RMW, memory word 0x11223344 at addr 0x30:
  - sh 0xABCD to addr 0x32 -> strobe data 0xABCD3344.
  - sb 0x55 to addr 0x30 -> 0xABCD3355.
  - 4-cycle occupancy each.
- Faults, each -> resp_fault=1 one cycle after accept, no strobe, resp_rdata=0:
  - lw addr 0x13
  - lh addr 0x31
  - size=3
  - addr 0x0100_0000 with ADDR_BITS=22
- Handshake: req_valid held high continuously -> req_ready low from E0+1 until the cycle after RESP; the second request is accepted exactly then.
- Reset mid-operation: assert reset during READ of a sb -> no strobe, no resp_valid, IDLE with all outputs at reset values next cycle; the memory word is unchanged.
